// File: rtl/endscreen_sequencer.sv
// End-of-game overlay sequencer: latches the outcome, freezes gameplay, and drives
// centred, pixel-scaled ROM addresses plus a restart pulse once the hold time has elapsed.
module endscreen_sequencer #(
  parameter int WIDTH       = 96,
  parameter int HEIGHT      = 72,
  parameter int SCALE_SH    = 2,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int HOLD_FRAMES = 180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        gamewin,
  input  logic        gamelose,
  input  logic        start_btn,
  output logic [12:0] rom_addr,
  output logic        overlay_en,
  output logic [1:0]  screen_sel,
  output logic        game_freeze,
  output logic        game_restart,
  output logic [1:0]  state
);

  localparam int X0 = (H_ACTIVE - (WIDTH  << SCALE_SH)) / 2;
  localparam int Y0 = (V_ACTIVE - (HEIGHT << SCALE_SH)) / 2;
  localparam int X1 = X0 + (WIDTH  << SCALE_SH);
  localparam int Y1 = Y0 + (HEIGHT << SCALE_SH);
  localparam int CW = $clog2(HOLD_FRAMES + 1);

  localparam logic [9:0]    X0L   = 10'(X0);
  localparam logic [9:0]    X1L   = 10'(X1);
  localparam logic [8:0]    Y0L   = 9'(Y0);
  localparam logic [8:0]    Y1L   = 9'(Y1);
  localparam logic [CW-1:0] HOLDL = CW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    WIN     = 2'd1,
    LOSE    = 2'd2,
    RESTART = 2'd3
  } state_t;

  state_t        cur, nxt;
  logic [CW-1:0] frames, frames_next;
  logic          tick;
  logic          showing;
  logic          in_win;
  logic [9:0]    dx;
  logic [8:0]    dy;
  logic [6:0]    col;
  logic [6:0]    row;
  logic [12:0]   addr;
  logic          en1;
  logic [1:0]    sel1;
  logic [1:0]    sel_now;

  assign tick    = (x == 10'd0) && (y == 9'd0);
  assign showing = (cur == WIN) || (cur == LOSE);
  assign in_win  = (x >= X0L) && (x < X1L) && (y >= Y0L) && (y < Y1L);
  assign dx      = x - X0L;
  assign dy      = y - Y0L;
  assign col     = 7'(dx >> SCALE_SH);
  assign row     = 7'(dy >> SCALE_SH);
  assign addr    = 13'(row) * 13'(WIDTH) + 13'(col);
  assign sel_now = (cur == WIN) ? 2'd1 : ((cur == LOSE) ? 2'd2 : 2'd0);
  assign state   = cur;

  // Outcome is latched on leaving PLAY; the hold counter only runs while a screen is shown.
  always_comb begin
    nxt         = cur;
    frames_next = frames;
    case (cur)
      PLAY: begin
        frames_next = '0;
        if (gamewin)       nxt = WIN;
        else if (gamelose) nxt = LOSE;
      end
      WIN, LOSE: begin
        if ((frames == HOLDL) && start_btn) nxt = RESTART;
        if (tick && (frames < HOLDL))       frames_next = frames + CW'(1);
      end
      RESTART: begin
        frames_next = '0;
        nxt         = PLAY;
      end
      default: nxt = PLAY;
    endcase
  end

  // Address stage then a second stage so overlay_en/screen_sel line up with ROM q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur          <= PLAY;
      frames       <= '0;
      game_freeze  <= 1'b0;
      game_restart <= 1'b0;
      rom_addr     <= '0;
      en1          <= 1'b0;
      sel1         <= '0;
      overlay_en   <= 1'b0;
      screen_sel   <= '0;
    end else begin
      cur          <= nxt;
      frames       <= frames_next;
      game_freeze  <= (nxt != PLAY);
      game_restart <= (nxt == RESTART);
      rom_addr     <= (showing && in_win) ? addr : 13'd0;
      en1          <= showing && in_win;
      sel1         <= sel_now;
      overlay_en   <= en1 && (nxt != RESTART);
      screen_sel   <= sel1;
    end
  end

endmodule
